// File: rtl/axi_wr_arbiter.sv
// rtl/axi_wr_arbiter.sv - two-master to one-slave AXI write-channel arbiter
//
// One owner holds the slave from AW through B; arbitration is round-robin
// and runs only in IDLE.
//
// Ports:
//   clock, reset       : rising-edge clock, asynchronous active-low reset
//   Mx_AW*, Mx_W*, Mx_B*: master x (x=0,1) write address/data/response channels
//   S_AW*, S_W*, S_B*  : shared slave write address/data/response channels
//   grant              : one-hot owner (bit0 = M0, bit1 = M1), 00 when idle
//   wlast_err          : single-cycle pulse when Wlast disagrees with the beat count

module axi_wr_arbiter #(
  parameter int DATAWIDTH = 32,
  parameter int IDWIDTH   = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   M0_AWvalid,
  output logic                   M0_AWready,
  input  logic [31:0]            M0_AWaddr,
  input  logic [IDWIDTH-1:0]     M0_AWid,
  input  logic [3:0]             M0_AWlen,
  input  logic [2:0]             M0_AWsize,
  input  logic [1:0]             M0_AWburst,
  input  logic                   M0_Wvalid,
  output logic                   M0_Wready,
  input  logic [DATAWIDTH-1:0]   M0_WData,
  input  logic [DATAWIDTH/8-1:0] M0_WStrb,
  input  logic                   M0_Wlast,
  output logic                   M0_Bvalid,
  input  logic                   M0_Bready,
  output logic [1:0]             M0_Bresp,
  output logic [IDWIDTH-1:0]     M0_Bid,
  input  logic                   M1_AWvalid,
  output logic                   M1_AWready,
  input  logic [31:0]            M1_AWaddr,
  input  logic [IDWIDTH-1:0]     M1_AWid,
  input  logic [3:0]             M1_AWlen,
  input  logic [2:0]             M1_AWsize,
  input  logic [1:0]             M1_AWburst,
  input  logic                   M1_Wvalid,
  output logic                   M1_Wready,
  input  logic [DATAWIDTH-1:0]   M1_WData,
  input  logic [DATAWIDTH/8-1:0] M1_WStrb,
  input  logic                   M1_Wlast,
  output logic                   M1_Bvalid,
  input  logic                   M1_Bready,
  output logic [1:0]             M1_Bresp,
  output logic [IDWIDTH-1:0]     M1_Bid,
  output logic                   S_AWvalid,
  input  logic                   S_AWready,
  output logic [31:0]            S_AWaddr,
  output logic [IDWIDTH-1:0]     S_AWid,
  output logic [3:0]             S_AWlen,
  output logic [2:0]             S_AWsize,
  output logic [1:0]             S_AWburst,
  output logic                   S_Wvalid,
  input  logic                   S_Wready,
  output logic [DATAWIDTH-1:0]   S_WData,
  output logic [DATAWIDTH/8-1:0] S_WStrb,
  output logic                   S_Wlast,
  input  logic                   S_Bvalid,
  output logic                   S_Bready,
  input  logic [1:0]             S_Bresp,
  input  logic [IDWIDTH-1:0]     S_Bid,
  output logic [1:0]             grant,
  output logic                   wlast_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       rr_q, rr_d;        // 0: M0 wins a tie, 1: M1 wins a tie
  logic [3:0] beat_q, beat_d;
  logic [3:0] len_q, len_d;
  logic       armed_q, armed_d;  // holds off arbitration for the first edge after reset

  logic sel1;
  logic in_addr, in_data, in_resp;
  logic sel_awvalid, sel_wvalid, sel_wlast, sel_bready;
  logic aw_hs, w_hs, b_hs, last_beat;

  assign sel1    = grant_q[1];
  assign in_addr = (state_q == ADDR);
  assign in_data = (state_q == DATA);
  assign in_resp = (state_q == RESP);

  assign sel_awvalid = sel1 ? M1_AWvalid : M0_AWvalid;
  assign sel_wvalid  = sel1 ? M1_Wvalid  : M0_Wvalid;
  assign sel_wlast   = sel1 ? M1_Wlast   : M0_Wlast;
  assign sel_bready  = sel1 ? M1_Bready  : M0_Bready;

  // Payload fields follow the grant mux; only the valids/readies are phase-gated.
  assign S_AWaddr  = sel1 ? M1_AWaddr  : M0_AWaddr;
  assign S_AWid    = sel1 ? M1_AWid    : M0_AWid;
  assign S_AWlen   = sel1 ? M1_AWlen   : M0_AWlen;
  assign S_AWsize  = sel1 ? M1_AWsize  : M0_AWsize;
  assign S_AWburst = sel1 ? M1_AWburst : M0_AWburst;
  assign S_WData   = sel1 ? M1_WData   : M0_WData;
  assign S_WStrb   = sel1 ? M1_WStrb   : M0_WStrb;
  assign S_Wlast   = sel_wlast;

  assign S_AWvalid  = in_addr & sel_awvalid;
  assign M0_AWready = in_addr & grant_q[0] & S_AWready;
  assign M1_AWready = in_addr & grant_q[1] & S_AWready;

  assign S_Wvalid  = in_data & sel_wvalid;
  assign M0_Wready = in_data & grant_q[0] & S_Wready;
  assign M1_Wready = in_data & grant_q[1] & S_Wready;

  // S_Bready stays low outside RESP so an early slave response is held, not lost.
  assign S_Bready  = in_resp & sel_bready;
  assign M0_Bvalid = in_resp & grant_q[0] & S_Bvalid;
  assign M1_Bvalid = in_resp & grant_q[1] & S_Bvalid;
  assign M0_Bresp  = S_Bresp;
  assign M1_Bresp  = S_Bresp;
  assign M0_Bid    = S_Bid;
  assign M1_Bid    = S_Bid;

  assign aw_hs     = S_AWvalid & S_AWready;
  assign w_hs      = S_Wvalid & S_Wready;
  assign b_hs      = S_Bvalid & S_Bready;
  assign last_beat = (beat_q == len_q);

  assign grant     = grant_q;
  assign wlast_err = w_hs & (sel_wlast != last_beat);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    beat_d  = beat_q;
    len_d   = len_q;
    armed_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (armed_q && (M0_AWvalid || M1_AWvalid)) begin
          if (M0_AWvalid && M1_AWvalid) begin
            grant_d = rr_q ? 2'b10 : 2'b01;
          end else begin
            grant_d = M1_AWvalid ? 2'b10 : 2'b01;
          end
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (aw_hs) begin
          beat_d  = 4'd0;
          len_d   = S_AWlen;
          state_d = DATA;
        end
      end
      DATA: begin
        // The count, not Wlast, ends the burst; the counter stops at AWlen.
        if (w_hs) begin
          if (last_beat) begin
            state_d = RESP;
          end else begin
            beat_d = beat_q + 4'd1;
          end
        end
      end
      RESP: begin
        if (b_hs) begin
          state_d = IDLE;
          grant_d = 2'b00;
          rr_d    = grant_q[0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      rr_q    <= 1'b0;
      beat_q  <= 4'd0;
      len_q   <= 4'd0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// tb/tb_axi_wr_arbiter.sv - self-checking bench for axi_wr_arbiter

module tb_axi_wr_arbiter;

  logic clock;
  logic reset;

  logic [1:0]  m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
  logic [31:0] m_awaddr [2];
  logic [3:0]  m_awid   [2];
  logic [3:0]  m_awlen  [2];
  logic [2:0]  m_awsize [2];
  logic [1:0]  m_awburst[2];
  logic [31:0] m_wdata  [2];
  logic [3:0]  m_wstrb  [2];
  logic [1:0]  m_bresp  [2];
  logic [3:0]  m_bid    [2];

  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
  logic [31:0] s_awaddr, s_wdata;
  logic [3:0]  s_awid, s_awlen, s_wstrb, s_bid;
  logic [2:0]  s_awsize;
  logic [1:0]  s_awburst, s_bresp;
  logic [1:0]  grant;
  logic        wlast_err;

  axi_wr_arbiter #(.DATAWIDTH(32), .IDWIDTH(4)) dut (
    .clock(clock), .reset(reset),
    .M0_AWvalid(m_awvalid[0]), .M0_AWready(m_awready[0]), .M0_AWaddr(m_awaddr[0]),
    .M0_AWid(m_awid[0]), .M0_AWlen(m_awlen[0]), .M0_AWsize(m_awsize[0]), .M0_AWburst(m_awburst[0]),
    .M0_Wvalid(m_wvalid[0]), .M0_Wready(m_wready[0]), .M0_WData(m_wdata[0]), .M0_WStrb(m_wstrb[0]),
    .M0_Wlast(m_wlast[0]), .M0_Bvalid(m_bvalid[0]), .M0_Bready(m_bready[0]), .M0_Bresp(m_bresp[0]),
    .M0_Bid(m_bid[0]),
    .M1_AWvalid(m_awvalid[1]), .M1_AWready(m_awready[1]), .M1_AWaddr(m_awaddr[1]),
    .M1_AWid(m_awid[1]), .M1_AWlen(m_awlen[1]), .M1_AWsize(m_awsize[1]), .M1_AWburst(m_awburst[1]),
    .M1_Wvalid(m_wvalid[1]), .M1_Wready(m_wready[1]), .M1_WData(m_wdata[1]), .M1_WStrb(m_wstrb[1]),
    .M1_Wlast(m_wlast[1]), .M1_Bvalid(m_bvalid[1]), .M1_Bready(m_bready[1]), .M1_Bresp(m_bresp[1]),
    .M1_Bid(m_bid[1]),
    .S_AWvalid(s_awvalid), .S_AWready(s_awready), .S_AWaddr(s_awaddr), .S_AWid(s_awid),
    .S_AWlen(s_awlen), .S_AWsize(s_awsize), .S_AWburst(s_awburst),
    .S_Wvalid(s_wvalid), .S_Wready(s_wready), .S_WData(s_wdata), .S_WStrb(s_wstrb), .S_Wlast(s_wlast),
    .S_Bvalid(s_bvalid), .S_Bready(s_bready), .S_Bresp(s_bresp), .S_Bid(s_bid),
    .grant(grant), .wlast_err(wlast_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests, n_fail;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- master agents ----------------
  int          j_issued[2], taken[2], j_len[2], j_err[2];
  logic [31:0] j_addr[2];
  logic [3:0]  j_id[2];
  bit          act[2], awd[2], tir[2];
  int          beat[2], a_len[2], a_err[2];
  logic [31:0] a_addr[2];
  logic [3:0]  a_id[2];
  int          done_cnt[2], b_cnt[2];
  logic [1:0]  last_bresp[2];
  logic [3:0]  last_bid[2];

  task automatic take_job(input int m);
    act[m] = 1'b1; awd[m] = 1'b0; beat[m] = 0;
    a_addr[m] = j_addr[m]; a_id[m] = j_id[m]; a_len[m] = j_len[m]; a_err[m] = j_err[m];
    taken[m]++;
  endtask

  always @(negedge clock) begin
    for (int m = 0; m < 2; m++) begin
      if (m_bvalid[m] && m_bready[m]) b_cnt[m]++;
      if (!reset) begin
        if (act[m] && !tir[m]) act[m] = 1'b0;
        else if (!act[m] && j_issued[m] > taken[m]) begin
          take_job(m);
          tir[m] = 1'b1;
        end
      end else begin
        if (act[m]) begin
          if (m_awvalid[m] && m_awready[m]) awd[m] = 1'b1;
          if (m_wvalid[m] && m_wready[m]) beat[m]++;
          if (m_bvalid[m] && m_bready[m]) begin
            act[m] = 1'b0;
            done_cnt[m]++;
            last_bresp[m] = m_bresp[m];
            last_bid[m] = m_bid[m];
          end
        end else if (j_issued[m] > taken[m]) begin
          take_job(m);
        end
        tir[m] = 1'b0;
      end
    end
  end

  always @(posedge clock) begin
    #1;
    for (int m = 0; m < 2; m++) begin
      m_awvalid[m] = act[m] && !awd[m];
      m_awaddr[m]  = a_addr[m];
      m_awid[m]    = a_id[m];
      m_awlen[m]   = a_len[m][3:0];
      m_awsize[m]  = 3'(2 + m);
      m_awburst[m] = 2'b01;
      m_wvalid[m]  = act[m] && awd[m] && (beat[m] <= a_len[m]);
      m_wdata[m]   = {8'hA0, 8'(m), 8'(a_len[m]), 8'(beat[m])};
      m_wstrb[m]   = 4'(beat[m] + 1);
      m_wlast[m]   = (beat[m] == a_len[m]) ^ (beat[m] == a_err[m]);
      m_bready[m]  = 1'b1;
    end
  end

  // ---------------- slave agent and monitors ----------------
  int         aw_delay, aw_wait, s_len, s_beats;
  bit         b_early, s_bpend, s_inburst;
  logic [3:0] s_bid_l;
  logic [1:0] bresp_cfg;
  int         beats_total, stall_cnt, bhold_cnt, err_cnt;
  logic [1:0] glog[$];
  logic [1:0] gprev;

  always @(negedge clock) begin
    if (grant !== gprev) glog.push_back(grant);
    gprev = grant;
    if (wlast_err) err_cnt++;
    if (!reset) begin
      aw_wait = 0; s_bpend = 1'b0; s_inburst = 1'b0; s_beats = 0;
    end else begin
      if (s_awvalid && !s_awready) begin aw_wait++; stall_cnt++; end
      if (s_awvalid && s_awready) begin
        aw_wait = 0; s_len = int'(s_awlen); s_bid_l = s_awid; s_beats = 0; s_inburst = 1'b1;
        if (b_early) s_bpend = 1'b1;
      end
      if (s_wvalid && s_wready) begin
        s_beats++; beats_total++;
        if (s_beats == s_len + 1) s_bpend = 1'b1;
      end
      if (s_bvalid && !s_bready) bhold_cnt++;
      if (s_bvalid && s_bready) begin s_bpend = 1'b0; s_inburst = 1'b0; end
    end
  end

  always @(posedge clock) begin
    #1;
    s_awready = (aw_wait >= aw_delay);
    s_wready  = 1'b1;
    s_bvalid  = s_bpend;
    s_bid     = s_bid_l;
    s_bresp   = bresp_cfg;
  end

  // ---------------- transaction-level reference model ----------------
  // Tracks one outstanding transaction as (owner, AW accepted, beats moved).
  int mo_owner, mo_beats, mo_len, mo_pref;
  bit mo_awd, mo_armed;

  always @(posedge clock) begin
    if (!reset) begin
      mo_owner <= -1; mo_awd <= 1'b0; mo_beats <= 0; mo_len <= 0; mo_pref <= 0; mo_armed <= 1'b0;
    end else if (!mo_armed) begin
      mo_armed <= 1'b1;
    end else if (mo_owner < 0) begin
      if (m_awvalid != 2'b00) begin
        mo_owner <= (m_awvalid == 2'b11) ? mo_pref : (m_awvalid[1] ? 1 : 0);
        mo_awd   <= 1'b0;
      end
    end else if (!mo_awd) begin
      if (m_awvalid[mo_owner] && s_awready) begin
        mo_awd <= 1'b1; mo_len <= int'(m_awlen[mo_owner]); mo_beats <= 0;
      end
    end else if (mo_beats <= mo_len) begin
      if (m_wvalid[mo_owner] && s_wready) mo_beats <= mo_beats + 1;
    end else if (m_bready[mo_owner] && s_bvalid) begin
      mo_pref  <= 1 - mo_owner;
      mo_owner <= -1;
    end
  end

  always @(negedge clock) begin
    int o;
    bit ea, ed, er;
    logic [1:0] eg;
    if (!reset) begin
      check("reset_outputs", {m_awready, m_wready, m_bvalid, s_awvalid, s_wvalid, s_bready, grant, wlast_err}, 64'd0);
    end else begin
      o  = (mo_owner < 0) ? 0 : mo_owner;
      ea = (mo_owner >= 0) && !mo_awd;
      ed = (mo_owner >= 0) && mo_awd && (mo_beats <= mo_len);
      er = (mo_owner >= 0) && mo_awd && (mo_beats > mo_len);
      eg = (mo_owner < 0) ? 2'b00 : ((mo_owner == 1) ? 2'b10 : 2'b01);
      check("grant", grant, eg);
      check("awready", m_awready, {ea && mo_owner == 1 && s_awready, ea && mo_owner == 0 && s_awready});
      check("wready", m_wready, {ed && mo_owner == 1 && s_wready, ed && mo_owner == 0 && s_wready});
      check("bvalid", m_bvalid, {er && mo_owner == 1 && s_bvalid, er && mo_owner == 0 && s_bvalid});
      check("s_awvalid", s_awvalid, ea && m_awvalid[o]);
      check("s_wvalid", s_wvalid, ed && m_wvalid[o]);
      check("s_bready", s_bready, er && m_bready[o]);
      check("wlast_err", wlast_err, ed && m_wvalid[o] && s_wready && (m_wlast[o] != (mo_beats == mo_len)));
      if (ea && m_awvalid[o])
        check("aw_fields", {s_awaddr, s_awid, s_awlen, s_awsize, s_awburst},
              {m_awaddr[o], m_awid[o], m_awlen[o], m_awsize[o], m_awburst[o]});
      if (ed && m_wvalid[o])
        check("w_fields", {s_wdata, s_wstrb, s_wlast}, {m_wdata[o], m_wstrb[o], m_wlast[o]});
      for (int m = 0; m < 2; m++)
        if (er && mo_owner == m && s_bvalid)
          check("b_fields", {m_bresp[m], m_bid[m]}, {s_bresp, s_bid});
    end
  end

  // ---------------- stimulus ----------------
  task automatic sync();
    @(posedge clock);
    #2;
  endtask

  task automatic issue(input int m, input logic [31:0] addr, input logic [3:0] id, input int len, input int err);
    j_addr[m] = addr; j_id[m] = id; j_len[m] = len; j_err[m] = err;
    j_issued[m]++;
  endtask

  task automatic wait_done(input int m, input int target, input int budget);
    int c = 0;
    while (done_cnt[m] < target && c < budget) begin
      @(negedge clock);
      c++;
    end
    n_tests++;
    if (done_cnt[m] < target) begin
      n_fail++;
      $display("FAIL timeout_m%0d: got %0d responses expected %0d", m, done_cnt[m], target);
    end
  endtask

  // Release mid-cycle; grant must stay 00 through the first rising edge.
  task automatic release_reset(input logic [1:0] exp_grant);
    @(posedge clock);
    #3;
    reset = 1'b1;
    @(negedge clock); check("rel_pre_edge", grant, 2'b00);
    @(negedge clock); check("rel_first_edge", grant, 2'b00);
    @(negedge clock); check("rel_second_edge", grant, exp_grant);
  endtask

  task automatic check_glog(input string name, input int n, input logic [7:0] exp);
    logic [7:0] pk;
    pk = 8'h00;
    check({name, "_len"}, glog.size(), n);
    for (int i = 0; i < glog.size() && i < 4; i++) pk[i*2 +: 2] = glog[i];
    check(name, pk, exp);
  endtask

  int base_beats, base_err, base_stall, base_bhold, base_b0, base_b1, d0, d1;

  initial begin
    n_tests = 0; n_fail = 0;
    reset = 1'b0;
    for (int m = 0; m < 2; m++) begin
      j_issued[m] = 0; taken[m] = 0; act[m] = 1'b0; awd[m] = 1'b0; tir[m] = 1'b0;
      beat[m] = 0; a_len[m] = 0; a_err[m] = -1; a_addr[m] = '0; a_id[m] = '0;
      done_cnt[m] = 0; b_cnt[m] = 0;
      m_awvalid[m] = 1'b0; m_wvalid[m] = 1'b0; m_bready[m] = 1'b0; m_wlast[m] = 1'b0;
      m_awaddr[m] = '0; m_awid[m] = '0; m_awlen[m] = '0; m_awsize[m] = '0; m_awburst[m] = '0;
      m_wdata[m] = '0; m_wstrb[m] = '0;
    end
    aw_delay = 0; aw_wait = 0; b_early = 1'b0; s_bpend = 1'b0; s_inburst = 1'b0;
    s_len = 0; s_beats = 0; s_bid_l = '0; bresp_cfg = 2'b00;
    beats_total = 0; stall_cnt = 0; bhold_cnt = 0; err_cnt = 0; gprev = 2'b00;
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bid = '0; s_bresp = '0;

    repeat (3) @(negedge clock);
    release_reset(2'b00);

    // M0 alone, 4-beat burst
    sync(); glog.delete();
    base_beats = beats_total; base_b0 = b_cnt[0]; base_b1 = b_cnt[1]; base_err = err_cnt;
    issue(0, 32'h0000_1000, 4'h3, 3, -1);
    wait_done(0, 1, 100);
    @(negedge clock);
    check("s1_beats", beats_total - base_beats, 4);
    check("s1_b_m0", b_cnt[0] - base_b0, 1);
    check("s1_b_m1", b_cnt[1] - base_b1, 0);
    check("s1_bresp", last_bresp[0], 2'b00);
    check("s1_bid", last_bid[0], 4'h3);
    check("s1_err", err_cnt - base_err, 0);
    check("s1_idle_grant", grant, 2'b00);
    check_glog("s1_glog", 2, 8'h01);

    // Both request together; pointer now favours M1
    sync(); glog.delete();
    d0 = done_cnt[0]; d1 = done_cnt[1];
    issue(0, 32'h0000_2000, 4'h4, 1, -1);
    issue(1, 32'h0000_3000, 4'h5, 1, -1);
    wait_done(1, d1 + 1, 100);
    wait_done(0, d0 + 1, 100);
    @(negedge clock);
    check_glog("rr_glog", 4, 8'h12);

    // M1 with Wlast raised early on its second beat
    sync(); bresp_cfg = 2'b10;
    base_beats = beats_total; base_err = err_cnt;
    issue(1, 32'h0000_4000, 4'h6, 3, 1);
    wait_done(1, done_cnt[1] + 1, 100);
    check("s3_beats", beats_total - base_beats, 4);
    check("s3_err", err_cnt - base_err, 1);
    check("s3_bresp", last_bresp[1], 2'b10);
    check("s3_bid", last_bid[1], 4'h6);
    bresp_cfg = 2'b00;

    // Slave raises Bvalid as soon as AW is accepted
    sync(); b_early = 1'b1;
    base_bhold = bhold_cnt; base_b0 = b_cnt[0];
    issue(0, 32'h0000_5000, 4'h7, 2, -1);
    wait_done(0, done_cnt[0] + 1, 100);
    check("s4_bhold", bhold_cnt - base_bhold, 3);
    check("s4_b_m0", b_cnt[0] - base_b0, 1);
    b_early = 1'b0;

    // Single-beat burst behind a 5-cycle AWready stall
    sync(); aw_delay = 5;
    base_stall = stall_cnt; base_beats = beats_total; base_err = err_cnt;
    issue(0, 32'h0000_6000, 4'h8, 0, -1);
    wait_done(0, done_cnt[0] + 1, 100);
    check("s6_stall", stall_cnt - base_stall, 5);
    check("s6_beats", beats_total - base_beats, 1);
    check("s6_err", err_cnt - base_err, 0);
    sync(); aw_delay = 0;

    // Simultaneous requests straight out of reset
    sync(); reset = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    d0 = done_cnt[0]; d1 = done_cnt[1];
    issue(0, 32'h0000_7000, 4'h1, 1, -1);
    issue(1, 32'h0000_8000, 4'h2, 2, -1);
    @(negedge clock); #1;
    glog.delete();
    release_reset(2'b01);
    wait_done(0, d0 + 1, 100);
    wait_done(1, d1 + 1, 100);
    @(negedge clock);
    check_glog("s2_glog", 4, 8'h21);

    // Reset during the third beat of an 8-beat burst, then a fresh M1 request
    sync();
    d0 = done_cnt[0]; d1 = done_cnt[1];
    issue(0, 32'h0000_9000, 4'hA, 7, -1);
    begin
      int c = 0;
      while (!(s_inburst && s_beats == 2) && c < 100) begin
        @(negedge clock); #1;
        c++;
      end
    end
    check("s5_mid_burst", {s_inburst, 4'(s_beats), s_wvalid}, {1'b1, 4'd2, 1'b1});
    reset = 1'b0;
    #1;
    check("s5_reset_now", {m_awready, m_wready, m_bvalid, s_awvalid, s_wvalid, s_bready, grant, wlast_err}, 64'd0);
    repeat (2) @(negedge clock);
    #1;
    issue(1, 32'h0000_A000, 4'h9, 1, -1);
    @(negedge clock); #1;
    release_reset(2'b10);
    base_beats = beats_total;
    wait_done(1, d1 + 1, 100);
    check("s5_m0_aborted", done_cnt[0] - d0, 0);
    check("s5_m1_beats", beats_total - base_beats, 2);
    check("s5_m1_bid", last_bid[1], 4'h9);

    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

endmodule

// File: doc/axi_wr_arbiter.md
AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 32, meaning the W-channel data width in bits; WStrb width is DATAWIDTH/8.
REQ-002 The block SHALL have parameter IDWIDTH, default 4, meaning the AWid/Bid width.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have ports Mx_AWvalid (input, 1) and Mx_AWready (output, 1), for x=0,1: the master x write-address handshake.
REQ-006 The block SHALL have these Mx inputs: Mx_AWaddr (32), Mx_AWid (IDWIDTH), Mx_AWlen (4), Mx_AWsize (3) and Mx_AWburst (2), giving the master x write-address fields.
REQ-007 The block SHALL have ports Mx_Wvalid (input, 1), Mx_Wready (output, 1), Mx_WData (input, DATAWIDTH), Mx_WStrb (input, DATAWIDTH/8) and Mx_Wlast (input, 1): the master x write-data channel.
REQ-008 The block SHALL have ports Mx_Bvalid (output, 1), Mx_Bready (input, 1), Mx_Bresp (output, 2) and Mx_Bid (output, IDWIDTH): the master x write-response channel.
REQ-009 The block SHALL have slave-side ports S_AW*, S_W* and S_B*, with the same names and widths as above and the opposite directions, facing the single shared slave.
REQ-010 The block SHALL have port grant, output, 2 bits: one-hot owner, where bit0 is M0 and bit1 is M1; 00 means idle.
REQ-011 The block SHALL have port wlast_err, output, 1 bit: a one-cycle pulse on a Wlast/beat-count mismatch.

Function
REQ-012 The block SHALL implement the FSM states IDLE, ADDR, DATA and RESP, with the state, grant, the rr pointer and a 4-bit beat counter all registered.
REQ-013 In IDLE, with any Mx_AWvalid=1, the block SHALL register a grant next cycle and go to ADDR; arbitration latency is 1 cycle and no handshake occurs in IDLE.
REQ-014 Arbitration SHALL be round-robin: with both requesting, the master not served last wins; with one requesting, that master wins regardless of the pointer.
REQ-015 In ADDR, the block SHALL route the granted master's AW fields and AWvalid to S_AW*, and S_AWready to its Mx_AWready, combinationally with zero added latency.
REQ-016 On an S_AWvalid&&S_AWready cycle, the block SHALL load the beat counter with 0, latch AWlen, and go to DATA.
REQ-017 In DATA, the block SHALL route the granted W channel; each S_Wvalid&&S_Wready cycle SHALL increment the counter.
REQ-018 On the beat where counter==latched AWlen, the block SHALL go to RESP; a burst SHALL be exactly AWlen+1 beats, and the counter SHALL NOT wrap.
REQ-019 If Wlast=1 on a beat other than the final one, or Wlast=0 on the final beat, the block SHALL pulse wlast_err for that cycle; the transfer SHALL still complete on the count.
REQ-020 In RESP, the block SHALL route S_Bvalid/S_Bresp/S_Bid to the granted master and its Mx_Bready to S_Bready.
REQ-021 On a B handshake, the block SHALL go to IDLE, clear grant, and set the rr pointer to the other master.
REQ-022 In any state other than RESP, S_Bready SHALL be 0; an early slave Bvalid is held off, not dropped.
REQ-023 The non-granted master SHALL see AWready=0, Wready=0 and Bvalid=0 at all times; when grant=00, all S_*valid and S_Bready SHALL be 0.
REQ-024 A request arriving from the losing master during a transaction SHALL wait, with no loss, and be served after the current owner's B handshake.
REQ-025 The grant SHALL change only in IDLE; the owner is fixed from AW through B (no interleaving).

Reset
REQ-026 On reset=0 the block SHALL, asynchronously: set state=IDLE, grant=00, rr pointer favouring M0, counter=0 and wlast_err=0, and drive all Mx_*ready, Mx_Bvalid, S_*valid and S_Bready low.
REQ-027 A reset asserted mid-burst SHALL abort the transaction with no further handshakes; after release, arbitration SHALL restart from IDLE.
REQ-028 After reset release, the first grant SHALL be issued no earlier than the second rising clock edge.

Verification
REQ-029 The bench SHALL cover: M0 alone, AWlen=3 -> grant=01, 4 W beats, Bresp=00 to M0 only, then grant=00 and the pointer favours M1.
REQ-030 The bench SHALL cover: M0 and M1 AWvalid on the same cycle after reset -> M0 served fully first, then M1, with grant sequence 01,00,10.
REQ-031 The bench SHALL cover: M1 Wlast=1 on beat 2 of AWlen=3 -> a wlast_err pulse on that cycle, with 4 beats still forwarded.
REQ-032 The bench SHALL cover: slave raises Bvalid during DATA -> S_Bready=0 until the last beat, then the B handshake in RESP.
REQ-033 The bench SHALL cover: reset=0 during beat 2 of AWlen=7 -> all valids and readies go low immediately; after release, a new M1 request completes normally.
REQ-034 The bench SHALL cover: AWlen=0 with S_AWready stalled 5 cycles -> AWvalid is held with stable fields, followed by a single-beat transfer.
